fifo_uart_tx: RTL

Serial transmitter that drains the transmit FIFO and shifts each word out as an asynchronous UART frame on a single line. It sits directly downstream of the FIFO and connects to its `rd`, `r_data` and `empty` ports. It pops one word whenever it is idle and the FIFO is non-empty. Bit timing comes from an internal programmable baud-tick generator with 16× oversampling.

---
 rtl/uart_pkg.sv | 15 +
 rtl/fifo_uart_tx_baud_gen.sv | 34 +++
 rtl/fifo_uart_tx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DVSR_WIDTH = 11;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// rtl/fifo_uart_tx_baud_gen.sv - programmable baud tick generator (module baud_gen)
module baud_gen
  import uart_pkg::*;
#(
  parameter int DVSR = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [DVSR_WIDTH-1:0] CNT_LAST = DVSR_WIDTH'(DVSR - 1);

  logic [DVSR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-draining UART transmitter, 16x oversampled bit timing
// Optional even-parity bit enabled by defining FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR       = 651
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  rd,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [TW-1:0]         s_q, s_d;
  logic [NW-1:0]         n_q, n_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  rd_q, rd_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  tick;
  logic                  clr;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign clr = (state_q == IDLE);

  baud_gen #(.DVSR(DVSR)) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    rd_d    = 1'b0;
    busy_d  = busy_q;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        // rd_q high means the FIFO pops on this edge, so the head word is taken now
        if (rd_q) begin
          b_d     = r_data;
`ifdef FIFO_UART_TX_PARITY_EN
          par_d   = ^r_data;
`endif
          s_d     = '0;
          busy_d  = 1'b1;
          state_d = START;
        end else begin
          rd_d = !empty;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == DATA_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == STOP_LAST) begin
            s_d     = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level follows the next state so tx comes straight from a flop
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      rd_q    <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign rd      = rd_q;
  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule
